// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    // Which master owns the slave bus; IDLE means no owner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // Wishbone cycle type identifiers.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Width of the ack watchdog counter.
    localparam int WD_W = 8;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog: counts strobe cycles without ack and flags expiry when the
// count reaches `timeout` (1..255). Expiry and clear both zero the count;
// clear has priority, so an ack on the expiry cycle wins.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int timeout = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WD_W-1:0] LAST_CNT = WD_W'(timeout - 1);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Expiry fires on the edge where the count would step to `timeout`.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST_CNT);

    // Next count: clear, wrap to zero on expiry, or count a waiting strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter in front of a single RAM slave.
// m0 = instruction fetch, m1 = data. The grant is held for the whole bus
// cycle (cyc high); a watchdog forces release when the slave never acks.
// Optional build macro: WB_ARB_ROUND_ROBIN_EN -- when defined, contention is
// resolved in favour of the master that was not granted last; otherwise m0
// always wins contention.
// Handshake: a master transfer completes on each cycle where its stb and the
// routed ack are both high; cyc frames the whole (possibly burst) cycle.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int dat_width = 16,
    parameter int adr_width = 16,
    parameter int timeout   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [dat_width-1:0] m0_dat_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [2:0]           m0_cti_i,
    output logic [dat_width-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [dat_width-1:0] m1_dat_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [2:0]           m1_cti_i,
    output logic [dat_width-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [adr_width-1:0] s_adr_o,
    output logic [dat_width-1:0] s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic [2:0]           s_cti_o,
    input  logic [dat_width-1:0] s_dat_i,
    input  logic                 s_ack_i,
    output logic [1:0]           state_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       m0_err_q, m0_err_d;
    logic       m1_err_q, m1_err_d;
    logic       wd_clr, wd_en, wd_expire;
    logic       pick_m1;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Alternate: on contention hand the bus to whoever did not have it last.
    assign pick_m1 = ~last_q;
`else
    // Fixed priority: m0 always wins contention.
    assign pick_m1 = 1'b0;
`endif

    // Watchdog only runs while a grant is held and the slave is stalling.
    assign wd_clr = (state_q == ST_IDLE) || s_ack_i;
    assign wd_en  = s_stb_o && !s_ack_i;

    wb_arb_watchdog #(
        .timeout (timeout)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // Grant FSM next state, last-granted tracking and timeout error pulses.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        m0_err_d = 1'b0;
        m1_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = pick_m1 ? ST_GNT1 : ST_GNT0;
                    last_d  = pick_m1;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0: begin
                if (wd_expire) begin
                    m0_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (wd_expire) begin
                    m1_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, last-granted and error registers; reset aborts any bus cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
        end
    end

    // Route the owner's request to the slave and the slave's ack to the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                m0_ack_o = s_ack_i;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_err_o = m0_err_q;
    assign m1_err_o = m1_err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2 with a behavioural RAM slave (registered ack, one
// wait state on single accesses, one beat per cycle on INCR bursts).
module tb_wb_arbiter2;

  localparam int TIMEOUT = 8;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr  [2];
  logic [15:0] m_wdat [2];
  logic [3:0]  m_sel  [2];
  logic [2:0]  m_cti  [2];
  logic [15:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [15:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic        s_ack;
  logic [1:0]  state;

  wb_arbiter2 #(.dat_width(16), .adr_width(16), .timeout(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_sel_i(m_sel[0]), .m0_cti_i(m_cti[0]),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_sel_i(m_sel[1]), .m1_cti_i(m_cti[1]),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_cti_o(s_cti),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .state_o(state)
  );

  // ---------------- RAM slave model ----------------
  logic [15:0] mem [1024];
  logic        s_ack_q;
  logic        slave_mute;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    s_ack_q = 1'b0;
  end

  always @(posedge clk) begin
    if (s_cyc && s_stb && s_ack && s_we) mem[s_adr[9:0]] <= s_wdat;
    s_ack_q <= s_cyc && s_stb && !slave_mute && (!s_ack_q || s_cti == 3'b010);
  end
  assign s_ack  = s_ack_q;
  assign s_rdat = mem[s_adr[9:0]];

  // ---------------- counters / literal checks ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural arbiter model ----------------
  // owner: -1 nobody, else master index. wait_cnt: stalled strobe cycles.
  int owner    = -1;
  int last_g   = 1;
  int wait_cnt = 0;
  int err_to   = -1;
  bit chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      owner = -1; last_g = 1; wait_cnt = 0; err_to = -1;
    end else begin
      err_to = -1;
      if (owner < 0) begin
        wait_cnt = 0;
        if (m_cyc[0] && m_cyc[1]) owner = RR ? (1 - last_g) : 0;
        else if (m_cyc[0]) owner = 0;
        else if (m_cyc[1]) owner = 1;
        if (owner >= 0) last_g = owner;
      end else begin
        if (s_ack) wait_cnt = 0;
        else if (m_stb[owner]) wait_cnt++;
        if (wait_cnt == TIMEOUT) begin
          err_to = owner; owner = -1; wait_cnt = 0;
        end else if (!m_cyc[owner]) begin
          owner = -1;
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  logic e_cyc, e_stb, e_we, cmp_ok;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      cmp_ok = 1'b1;
      if (owner >= 0) begin
        e_cyc = m_cyc[owner]; e_stb = m_stb[owner]; e_we = m_we[owner];
        if (s_adr !== m_adr[owner] || s_wdat !== m_wdat[owner] ||
            s_sel !== m_sel[owner] || s_cti !== m_cti[owner]) cmp_ok = 1'b0;
      end
      if (s_cyc !== e_cyc || s_stb !== e_stb || s_we !== e_we) cmp_ok = 1'b0;
      if (m0_ack !== (owner == 0 && s_ack)) cmp_ok = 1'b0;
      if (m1_ack !== (owner == 1 && s_ack)) cmp_ok = 1'b0;
      if (m0_err !== (err_to == 0) || m1_err !== (err_to == 1)) cmp_ok = 1'b0;
      if (m0_rdat !== s_rdat || m1_rdat !== s_rdat) cmp_ok = 1'b0;
      n_checks++;
      if (cmp_ok) n_pass++;
      else $display("FAIL cycle_cmp t=%0t got cyc/stb/we=%b%b%b ack=%b%b err=%b%b exp cyc/stb/we=%b%b%b owner=%0d err_to=%0d",
                    $time, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err,
                    e_cyc, e_stb, e_we, owner, err_to);
    end
  end

  // ---------------- driver tasks ----------------
  int     order_q[$];
  time    done_t [2];
  time    burst_done_t;
  logic [15:0] exp_q[$];

  task automatic wb_single(input int m, input logic we, input logic [15:0] adr,
                           input logic [15:0] wdat, output logic [15:0] rd, output int lat);
    bit got;
    @(posedge clk); #1;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr; m_wdat[m] = wdat; m_sel[m] = 4'hF; m_cti[m] = 3'b000;
    lat = 0; got = 1'b0; rd = 16'h0;
    while (!got && lat < 64) begin
      @(negedge clk); lat++;
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        rd = (m == 0) ? m0_rdat : m1_rdat;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout master=%0d adr=0x%0h got no ack required ack within 64 cycles", m, adr);
    end else begin
      order_q.push_back(m);
      done_t[m] = $time;
    end
    @(posedge clk); #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  task automatic m1_burst_write(input logic [15:0] base, input logic [15:0] d0);
    bit got;
    int n;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'hF;
    for (int b = 0; b < 4; b++) begin
      m_adr[1] = base + 16'(b); m_wdat[1] = d0 + 16'(b);
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      got = 1'b0; n = 0;
      while (!got && n < 64) begin
        @(negedge clk); n++;
        if (m1_ack) got = 1'b1;
      end
      if (!got) begin
        n_checks++;
        $display("FAIL burst_timeout beat=%0d got no ack required ack within 64 cycles", b);
        break;
      end
      @(posedge clk); #1;
    end
    burst_done_t = $time;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0; m_cti[1] = 3'b000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] rd;
  int lat, errat;

  initial begin
    rst_n = 1'b0; slave_mute = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_wdat[i] = '0; m_sel[i] = '0; m_cti[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_ctrl", {29'd0, s_cyc, s_stb, s_we}, 32'd0);
    check("reset_err", {30'd0, m0_err, m1_err}, 32'd0);

    // m0 single read of 0x0010: grant 1 cycle, ack 1 cycle later
    wb_single(0, 1'b0, 16'h0010, 16'h0, rd, lat);
    check("m0_read_data", rd, 16'hBEEF);
    check("m0_read_latency", lat, 3);

    // Contention right after reset (last = 1)
    do_reset();
    order_q.delete();
    fork
      begin
        logic [15:0] r; int l;
        wb_single(0, 1'b0, 16'h0010, 16'h0, r, l);
        check("cont_m0a_data", r, 16'hBEEF);
        wb_single(0, 1'b0, 16'h0011, 16'h0, r, l);
        check("cont_m0b_data", r, 16'h0000);
      end
      begin
        logic [15:0] r; int l;
        wb_single(1, 1'b0, 16'h0010, 16'h0, r, l);
        check("cont_m1_data", r, 16'hBEEF);
      end
    join
    check("cont_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("cont_first", order_q[0], 0);
      check("cont_second", order_q[1], RR ? 1 : 0);
      check("cont_third", order_q[2], RR ? 0 : 1);
    end

    // m1 burst write while m0 requests: m0 waits for the whole burst
    fork
      m1_burst_write(16'h0100, 16'hA000);
      begin
        logic [15:0] r; int l;
        repeat (2) @(posedge clk);
        wb_single(0, 1'b0, 16'h0010, 16'h0, r, l);
        check("burst_m0_data", r, 16'hBEEF);
      end
    join
    check("burst_m0_after", {31'd0, done_t[0] > burst_done_t}, 32'd1);
    for (int b = 0; b < 4; b++) exp_q.push_back(16'hA000 + 16'(b));
    for (int b = 0; b < 4; b++) begin
      logic [15:0] e;
      wb_single(1, 1'b0, 16'h0100 + 16'(b), 16'h0, rd, lat);
      e = exp_q.pop_front();
      check("burst_readback", rd, e);
    end

    // Watchdog: slave mute, m0 strobes, m1 requests behind it
    slave_mute = 1'b1;
    errat = 0;
    fork
      begin
        int n;
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[0] = 16'h0020; m_cti[0] = 3'b000;
        n = 0;
        while (errat == 0 && n < 40) begin
          @(negedge clk); n++;
          if (m0_err) begin
            errat = n;
            m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
            slave_mute = 1'b0;
          end
        end
        if (errat == 0) begin
          slave_mute = 1'b0;
          m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        end
        @(negedge clk);
        check("wd_err_one_cycle", {31'd0, m0_err}, 32'd0);
        check("wd_m1_granted", {15'd0, s_cyc, s_adr}, {15'd0, 1'b1, 16'h0010});
      end
      begin
        logic [15:0] r; int l;
        @(posedge clk);
        wb_single(1, 1'b0, 16'h0010, 16'h0, r, l);
        check("wd_m1_data", r, 16'hBEEF);
      end
    join
    check("wd_err_cycle", errat, 10);

    // Reset in the middle of an m1 burst
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = 16'h0200; m_wdat[1] = 16'h5555; m_cti[1] = 3'b010;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state", {30'd0, state}, 32'd0);
    check("rst_mid_ctrl", {29'd0, s_cyc, s_stb, s_we}, 32'd0);
    check("rst_mid_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    rst_n = 1'b1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0; m_cti[1] = 3'b000;

    // Normal m0 accesses after reset
    wb_single(0, 1'b1, 16'h0030, 16'h1234, rd, lat);
    wb_single(0, 1'b0, 16'h0030, 16'h0, rd, lat);
    check("post_rst_rw", rd, 16'h1234);
    wb_single(0, 1'b0, 16'h0010, 16'h0, rd, lat);
    check("post_rst_read", rd, 16'hBEEF);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter placed in front of the `ram_wb` slave, letting an instruction-fetch master (m0) and a data master (m1) share one RAM port. It owns the grant for the whole bus cycle (`cyc` high), including registered-feedback bursts, and muxes address, data and control to the slave. A watchdog releases a grant whose slave never acknowledges.

## Interface
Parameters:
- `dat_width`, 16, data bus width; matches the RAM slave.
- `adr_width`, 16, address bus width.
- `timeout`, 255, cycles a strobe may wait for ack before forced release; range 1..255.

Ports:
- `clk_i`  input  1  single clock; all logic on rising edge.
- `rst_i`  input  1  reset; synchronous, active-low.
- `m0_cyc_i` / `m1_cyc_i`  input  1  master bus-cycle request.
- `m0_stb_i` / `m1_stb_i`  input  1  master strobe.
- `m0_we_i` / `m1_we_i`  input  1  write enable.
- `m0_adr_i` / `m1_adr_i`  input  adr_width  address.
- `m0_dat_i` / `m1_dat_i`  input  dat_width  write data.
- `m0_sel_i` / `m1_sel_i`  input  4  byte selects.
- `m0_cti_i` / `m1_cti_i`  input  3  cycle type identifier.
- `m0_dat_o` / `m1_dat_o`  output  dat_width  read data; `s_dat_i` broadcast to both masters.
- `m0_ack_o` / `m1_ack_o`  output  1  ack; owner only.
- `m0_err_o` / `m1_err_o`  output  1  one-cycle timeout pulse to the owner.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  output  1  to slave.
- `s_adr_o`  output  adr_width; `s_dat_o`  output  dat_width; `s_sel_o`  output  4; `s_cti_o`  output  3.
- `s_dat_i`  input  dat_width; `s_ack_i`  input  1  from slave.

## Operation
- FSM states: IDLE, GNT0, GNT1; state register updated on the clock edge.
- IDLE: no `cyc` → stay. One requester → GNTx for that master. Both requesting → priority rule (see Configuration).
- GNTx: slave outputs = master x inputs; `s_cyc_o` = `mx_cyc_i`, `s_stb_o` = `mx_stb_i`; `mx_ack_o` = `s_ack_i`. The other master sees ack 0, err 0.
- GNTx → IDLE when `mx_cyc_i` = 0, or on watchdog expiry. No direct GNT0↔GNT1 handoff.
- In IDLE all slave control outputs (`s_cyc_o`, `s_stb_o`, `s_we_o`) are 0. `s_adr_o`, `s_dat_o`, `s_sel_o` and `s_cti_o` are driven from m0 and are don't-care.
- Watchdog: an 8-bit counter.
  - Clears in IDLE and on every cycle with `s_ack_i` = 1.
  - Increments when `s_stb_o` = 1 and `s_ack_i` = 0.
  - When it reaches `timeout`: `mx_err_o` = 1 for exactly one cycle, state → IDLE, counter → 0.
- `last` register records the most recently granted master; it is updated on every IDLE→GNTx transition.
- Reset (`rst_i` = 0 at an edge): state IDLE, `last` = 1, counter 0, both err 0. This aborts any in-flight cycle. Outputs are reset values from the following cycle.

## Timing
- Arbitration latency: 1 cycle. Request seen in IDLE at edge n → `s_cyc_o` high after edge n.
- Ack/data path is combinational slave→owner. The RAM's registered ack gives 1 wait state per single access; bursts (cti 010) stream one beat per cycle.
- Release: owner drops `cyc` at edge n → IDLE after edge n → the next grant becomes visible after edge n+1, giving a 1-cycle bus gap.
- A watchdog error fires at the edge where the count equals `timeout`. If the owner still holds `cyc`, it is re-arbitrated normally from IDLE.
- Simultaneous release and other request: IDLE first, then grant. Simultaneous ack and expiry: ack wins and the counter clears.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined: on contention in IDLE, grant the master that is not `last`. This makes the two masters alternate.
- Undefined: fixed priority, with m0 always winning contention. `last` is still maintained but ignored.

## Structure
- Package `wb_arb_pkg`:
  - state enum (IDLE/GNT0/GNT1);
  - CTI constants: CLASSIC 000, INCR 010, EOB 111;
  - watchdog counter width 8.
- Sub-module `wb_arb_watchdog`: counter with clear/enable inputs and an expire output; parameterised by `timeout`.
- Datapath muxing stays in the top level.

## Test plan
- Reset, then m0 single read at 0x0010 (RAM holds 0xBEEF): grant after 1 cycle, `m0_ack_o` 1 cycle later, `m0_dat_o` = 0xBEEF, `m1_ack_o` stays 0.
- m0 and m1 both raise `cyc` in the same cycle:
  - round-robin build: m0 first (`last` = 1 after reset), then m1 after m0 releases;
  - fixed build: m0, and m0 again on re-request.
- m1 4-beat burst write (cti 010,010,010,111) to 0x0100..0x0103 while m0 requests: m0 waits the whole burst. Readback of 0x0100..0x0103 returns the written values.
- Slave ack tied 0, `timeout` = 8, m0 strobes: `m0_err_o` pulses exactly at cycle 8 after the strobe, state returns to IDLE, m1 is granted next.
- `rst_i` driven low mid-burst of m1: the next cycle shows IDLE, all slave control outputs 0, no acks; a normal m0 access succeeds afterwards.
